// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle logic/arith ops plus iterative unsigned multiply
// (shift-add) and unsigned divide (restoring), one bit per clock.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [3:0]       aluOP,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] hi,
    output logic             zeroFlag,
    output logic             overflow
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    localparam logic [3:0]      OP_MULTU = 4'd8;
    localparam logic [3:0]      OP_DIVU  = 4'd9;
    localparam logic [CNTW-1:0] LAST     = CNTW'(WIDTH - 1);

    state_t           state;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] acc_hi;   // partial product high half / running remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier being consumed / dividend becoming quotient
    logic [WIDTH-1:0] opb;      // multiplicand / divisor
    logic             eq_lat;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    always_comb begin
        sum     = in1 + in2;
        diff    = in1 - in2;
        alu_res = '0;
        alu_ovf = 1'b0;
        case (aluOP)
            4'd0: alu_res = in1 & in2;
            4'd1: alu_res = in1 | in2;
            4'd2: begin
                alu_res = sum;
                alu_ovf = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            4'd3: begin
                alu_res = diff;
                alu_ovf = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff[WIDTH-1] != in1[WIDTH-1]);
            end
            4'd4: alu_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            4'd5: alu_res = ~(in1 | in2);
            4'd6: alu_res = in1 ^ in2;
            4'd7: alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
            default: alu_res = '0;
        endcase
    end

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem_n;
    logic [WIDTH-1:0] div_quo_n;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_hi_n  = mul_sum[WIDTH:1];
        mul_lo_n  = {mul_sum[0], acc_lo[WIDTH-1:1]};
        // Remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        div_ok    = ~div_diff[WIDTH];
        div_rem_n = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo_n = {acc_lo[WIDTH-2:0], div_ok};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            eq_lat   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            hi       <= '0;
            zeroFlag <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    if (start) begin
                        eq_lat <= (in1 == in2);
                        acc_hi <= '0;
                        acc_lo <= in1;
                        opb    <= in2;
                        cnt    <= '0;
                        if (aluOP == OP_MULTU) begin
                            state <= MUL;
                            busy  <= 1'b1;
                        end else if (aluOP == OP_DIVU && in2 == '0) begin
                            state    <= FIN;
                            done     <= 1'b1;
                            out      <= '1;
                            hi       <= in1;
                            zeroFlag <= (in1 == in2);
                            overflow <= 1'b0;
                        end else if (aluOP == OP_DIVU) begin
                            state <= DIV;
                            busy  <= 1'b1;
                        end else begin
                            done     <= 1'b1;
                            out      <= alu_res;
                            zeroFlag <= (in1 == in2);
                            overflow <= alu_ovf;
                        end
                    end
                end
                MUL: begin
                    acc_hi <= mul_hi_n;
                    acc_lo <= mul_lo_n;
                    cnt    <= cnt + CNTW'(1);
                    if (cnt == LAST) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        out      <= mul_lo_n;
                        hi       <= mul_hi_n;
                        zeroFlag <= eq_lat;
                        overflow <= 1'b0;
                    end
                end
                DIV: begin
                    acc_hi <= div_rem_n;
                    acc_lo <= div_quo_n;
                    cnt    <= cnt + CNTW'(1);
                    if (cnt == LAST) begin
                        state    <= FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        out      <= div_quo_n;
                        hi       <= div_rem_n;
                        zeroFlag <= eq_lat;
                        overflow <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu: expected results queued at issue,
// popped and compared when done is observed.
module tb_multicycle_alu;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [W-1:0] in1, in2;
    logic [3:0]   aluOP;
    logic         busy, done;
    logic [W-1:0] out, hi;
    logic         zeroFlag, overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] o;
        logic [W-1:0] h;
        logic         z;
        logic         v;
        int           lat;
        int           bsy;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] model_hi;

    multicycle_alu #(.WIDTH(W), .CNTW(6)) dut (
        .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .aluOP(aluOP),
        .busy(busy), .done(done), .out(out), .hi(hi),
        .zeroFlag(zeroFlag), .overflow(overflow)
    );

    always #5 clk = ~clk;

    function automatic exp_t predict(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] prev_hi);
        exp_t         e;
        logic [2*W-1:0] prod;
        logic [W-1:0] s;
        e.op = op; e.h = prev_hi; e.z = (a == b); e.v = 1'b0; e.lat = 1; e.bsy = 0; e.o = '0;
        case (op)
            4'd0: e.o = a & b;
            4'd1: e.o = a | b;
            4'd2: begin s = a + b; e.o = s; e.v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]); end
            4'd3: begin s = a - b; e.o = s; e.v = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]); end
            4'd4: e.o = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5: e.o = ~(a | b);
            4'd6: e.o = a ^ b;
            4'd7: e.o = (a < b) ? 32'd1 : 32'd0;
            4'd8: begin
                prod = {32'd0, a} * {32'd0, b};
                e.o = prod[W-1:0]; e.h = prod[2*W-1:W]; e.lat = W + 1; e.bsy = W;
            end
            4'd9: begin
                if (b == 0) begin e.o = '1; e.h = a; end
                else begin e.o = a / b; e.h = a % b; e.lat = W + 1; e.bsy = W; end
            end
            default: e.o = '0;
        endcase
        return e;
    endfunction

    task automatic push(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e = predict(op, a, b, model_hi);
        model_hi = e.h;
        q.push_back(e);
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        aluOP = op; in1 = a; in2 = b; start = 1'b1;
        push(op, a, b);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Latency counts the accept edge as 1; bounded so a missing done cannot hang.
    task automatic wait_done(output int lat, output int bsy);
        lat = 1; bsy = 0;
        while (!done && lat < 200) begin
            if (busy) bsy++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; aluOP = '0; model_hi = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, out, hi, zeroFlag, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_state got busy=%b done=%b out=%h hi=%h z=%b v=%b want all 0",
                     busy, done, out, hi, zeroFlag, overflow);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_ops();
        logic [3:0]   ops[12] = '{4'd2, 4'd4, 4'd7, 4'd3, 4'd0, 4'd1, 4'd5, 4'd6, 4'd3, 4'd2, 4'd12, 4'd15};
        logic [W-1:0] as[12]  = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd9, 32'hF0F0_1234, 32'hF0F0_1234,
                                  32'h0F0F_0000, 32'hAAAA_5555, 32'h8000_0000, 32'hFFFF_FFFF, 32'd77, 32'd5};
        logic [W-1:0] bs[12]  = '{32'd1, 32'd1, 32'd1, 32'd9, 32'h0FF0_FF00, 32'h0FF0_FF00,
                                  32'h0000_F0F0, 32'hFFFF_0000, 32'd1, 32'd1, 32'd77, 32'd6};
        exp_t e;
        int   lat, bsy;
        logic [W-1:0] held;
        for (int i = 0; i < 12; i++) begin
            issue(ops[i], as[i], bs[i]);
            wait_done(lat, bsy);
            e = q.pop_front();
            checks++;
            if (lat !== e.lat || bsy !== 0) begin
                errors++;
                $display("FAIL alu_timing[%0d] op=%0d got lat=%0d busy_cycles=%0d want lat=%0d busy_cycles=0",
                         i, e.op, lat, bsy, e.lat);
            end
            checks++;
            if (out !== e.o || hi !== e.h || zeroFlag !== e.z || overflow !== e.v) begin
                errors++;
                $display("FAIL alu_result[%0d] op=%0d got out=%h hi=%h z=%b v=%b want out=%h hi=%h z=%b v=%b",
                         i, e.op, out, hi, zeroFlag, overflow, e.o, e.h, e.z, e.v);
            end
            held = out;
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || out !== held) begin
                errors++;
                $display("FAIL alu_hold[%0d] got done=%b out=%h want done=0 out=%h", i, done, out, held);
            end
        end
    endtask

    task automatic test_multicycle();
        logic [3:0]   ops[5] = '{4'd8, 4'd9, 4'd9, 4'd8, 4'd9};
        logic [W-1:0] as[5]  = '{32'hFFFFFFFF, 32'd100, 32'd5, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [W-1:0] bs[5]  = '{32'hFFFFFFFF, 32'd7, 32'd0, 32'h9ABC_DEF0, 32'h0000_1234};
        exp_t e;
        int   lat, bsy;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i]);
            // Operands changing while busy must not disturb the latched operation.
            in1 = $urandom; in2 = $urandom; aluOP = 4'($urandom_range(0, 15));
            wait_done(lat, bsy);
            e = q.pop_front();
            checks++;
            if (lat !== e.lat || bsy !== e.bsy) begin
                errors++;
                $display("FAIL mc_timing[%0d] op=%0d got lat=%0d busy_cycles=%0d want lat=%0d busy_cycles=%0d",
                         i, e.op, lat, bsy, e.lat, e.bsy);
            end
            checks++;
            if (out !== e.o || hi !== e.h || zeroFlag !== e.z || overflow !== e.v) begin
                errors++;
                $display("FAIL mc_result[%0d] op=%0d got out=%h hi=%h z=%b v=%b want out=%h hi=%h z=%b v=%b",
                         i, e.op, out, hi, zeroFlag, overflow, e.o, e.h, e.z, e.v);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mc_after[%0d] got done=%b busy=%b want 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_reset_abort();
        int   dones = 0;
        int   lat, bsy;
        exp_t e;
        issue(4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q.delete();
        model_hi = '0;
        checks++;
        if ({busy, done, out, hi, zeroFlag, overflow} !== '0) begin
            errors++;
            $display("FAIL abort_state got busy=%b done=%b out=%h hi=%h z=%b v=%b want all 0",
                     busy, done, out, hi, zeroFlag, overflow);
        end
        issue(4'd2, 32'd2, 32'd3);
        wait_done(lat, bsy);
        e = q.pop_front();
        checks++;
        if (lat !== 1 || out !== e.o || hi !== e.h || overflow !== e.v) begin
            errors++;
            $display("FAIL abort_add got lat=%0d out=%h hi=%h v=%b want lat=1 out=%h hi=%h v=%b",
                     lat, out, hi, overflow, e.o, e.h, e.v);
        end
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL abort_no_done got %0d done pulses want 0", dones);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat, bsy;
        aluOP = 4'd9; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
        push(4'd9, 32'd100, 32'd7);
        @(posedge clk); #1;
        aluOP = 4'd2; in1 = 32'd2; in2 = 32'd3;
        push(4'd2, 32'd2, 32'd3);
        wait_done(lat, bsy);
        e = q.pop_front();
        checks++;
        if (lat !== e.lat || out !== e.o || hi !== e.h || zeroFlag !== e.z) begin
            errors++;
            $display("FAIL b2b_div got lat=%0d out=%h hi=%h z=%b want lat=%0d out=%h hi=%h z=%b",
                     lat, out, hi, zeroFlag, e.lat, e.o, e.h, e.z);
        end
        @(posedge clk); #1;
        start = 1'b0;
        e = q.pop_front();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out !== e.o || hi !== e.h || overflow !== e.v) begin
            errors++;
            $display("FAIL b2b_add got done=%b busy=%b out=%h hi=%h v=%b want done=1 busy=0 out=%h hi=%h v=%b",
                     done, busy, out, hi, overflow, e.o, e.h, e.v);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle got done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_multicycle();
        test_reset_abort();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
